// File: rtl/hist_readout.sv
// hist_readout: streams a completed histogram bin by bin over valid/ready and tracks the peak bin.
// Define READ_CLEAR_EN to zero each bin in memory right after its count is captured.
module hist_readout #(
    parameter int NP     = 10,
    parameter int NBINS  = 1024,
    parameter int PEAK_W = 21
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [NP-1:0]     rd_addr,
    input  logic [PEAK_W-1:0] rd_data,
    output logic              clr_we,
    output logic [NP-1:0]     clr_addr,
    output logic              bin_valid,
    input  logic              bin_ready,
    output logic [NP-1:0]     bin_addr,
    output logic [PEAK_W-1:0] bin_count,
    output logic [NP-1:0]     peak_addr,
    output logic [PEAK_W-1:0] peak_count,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, DONE} state_t;
    localparam logic [NP-1:0] LAST = NP'(NBINS - 1);

    state_t              state, state_n;
    logic [NP-1:0]       ptr, ptr_n, rd_addr_n, bin_addr_n, peak_addr_n;
    logic [PEAK_W-1:0]   bin_count_n, peak_count_n;
    logic                busy_n, rd_en_n, bin_valid_n, done_n;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            bin_valid  <= 1'b0;
            bin_addr   <= '0;
            bin_count  <= '0;
            peak_addr  <= '0;
            peak_count <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            busy       <= busy_n;
            rd_en      <= rd_en_n;
            rd_addr    <= rd_addr_n;
            bin_valid  <= bin_valid_n;
            bin_addr   <= bin_addr_n;
            bin_count  <= bin_count_n;
            peak_addr  <= peak_addr_n;
            peak_count <= peak_count_n;
            done       <= done_n;
        end
    end

    // Outputs are registered, so each state computes the values they take on the next edge.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        busy_n       = busy;
        rd_en_n      = 1'b0;
        rd_addr_n    = rd_addr;
        bin_valid_n  = bin_valid;
        bin_addr_n   = bin_addr;
        bin_count_n  = bin_count;
        peak_addr_n  = peak_addr;
        peak_count_n = peak_count;
        done_n       = 1'b0;
        case (state)
            IDLE: if (start) begin
                ptr_n        = '0;
                peak_addr_n  = '0;
                peak_count_n = '0;
                busy_n       = 1'b1;
                rd_en_n      = 1'b1;
                rd_addr_n    = '0;
                state_n      = READ;
            end
            READ: state_n = CAPT;
            CAPT: begin
                bin_count_n  = rd_data;
                bin_addr_n   = ptr;
                bin_valid_n  = 1'b1;
                peak_count_n = rd_data > peak_count ? rd_data : peak_count;
                peak_addr_n  = rd_data > peak_count ? ptr : peak_addr;
                state_n      = SEND;
            end
            SEND: if (bin_ready) begin
                bin_valid_n = 1'b0;
                done_n      = ptr == LAST;
                rd_en_n     = ptr != LAST;
                ptr_n       = ptr == LAST ? ptr : ptr + 1'b1;
                rd_addr_n   = ptr == LAST ? rd_addr : ptr + 1'b1;
                state_n     = ptr == LAST ? DONE : READ;
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef READ_CLEAR_EN
    // The clear lands in CAPT, after the read data for this bin has left the memory.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            clr_we   <= 1'b0;
            clr_addr <= '0;
        end else begin
            clr_we   <= state == READ;
            clr_addr <= state == READ ? ptr : clr_addr;
        end
    end
`else
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif
endmodule

// File: tb/tb_hist_readout.sv
// tb_hist_readout: directed frame vectors against a small memory model for hist_readout.
module tb_hist_readout;
    localparam int NP = 10;
    localparam int NB = 4;
    localparam int W  = 21;

    logic clk = 1'b0, res = 1'b0, start = 1'b0, bin_ready = 1'b1;
    logic busy, rd_en, clr_we, bin_valid, done;
    logic [NP-1:0] rd_addr, clr_addr, bin_addr, peak_addr;
    logic [W-1:0]  rd_data = '0, bin_count, peak_count;
    logic [W-1:0]  mem [NB];
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [W-1:0]  m [NB];
        int            sb;
        int            sl;
        bit            sad;
        logic [NP-1:0] pa;
        logic [W-1:0]  pc;
        int            dn;
    } vec_t;
    vec_t vecs [6];

    hist_readout #(.NP(NP), .NBINS(NB), .PEAK_W(W)) dut (
        .clk(clk), .res(res), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .clr_we(clr_we), .clr_addr(clr_addr),
        .bin_valid(bin_valid), .bin_ready(bin_ready),
        .bin_addr(bin_addr), .bin_count(bin_count),
        .peak_addr(peak_addr), .peak_count(peak_count), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[1:0]];
        if (clr_we) mem[clr_addr[1:0]] <= '0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctrl"}, {busy, rd_en, clr_we, bin_valid, done, rd_addr, clr_addr, bin_addr}, 0);
        chk({name, "_data"}, {bin_count, peak_count, peak_addr}, 0);
    endtask

    task automatic run_frame(input logic [W-1:0] ec [NB], input int sb, input int sl, input bit sad,
                             input logic [NP-1:0] pa, input logic [W-1:0] pc, input int dn);
        int idx = 0, left = sl, dcount = 0;
        bit prd = 1'b0;
        logic [NP-1:0] pra = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < dn + 4; n++) begin
            @(negedge clk);
            if (n == 0) chk("busy_after_start", busy, 1);
            if (rd_en) begin
                chk("rd_addr", rd_addr, idx);
                chk("rd_while_valid", bin_valid, 0);
            end
`ifdef READ_CLEAR_EN
            chk("clr_we", clr_we, prd);
            if (prd) chk("clr_addr", clr_addr, pra);
`else
            chk("clr_tied", {clr_we, clr_addr}, 0);
`endif
            prd = rd_en;
            pra = rd_addr;
            if (bin_valid) begin
                chk("bin_addr", bin_addr, idx);
                chk("bin_count", bin_count, idx < NB ? ec[idx] : '1);
                bin_ready = !(idx == sb && left > 0);
                if (!bin_ready) left--;
                else idx++;
            end else bin_ready = 1'b1;
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    chk("done_cycle", n, dn);
                    chk("peak_addr", peak_addr, pa);
                    chk("peak_count", peak_count, pc);
                    chk("bins_seen", idx, NB);
                end
                if (sad) start = 1'b1;
            end else start = 1'b0;
        end
        bin_ready = 1'b1;
        chk("done_pulses", dcount, 1);
        chk("busy_end", busy, 0);
        chk("peak_addr_hold", peak_addr, pa);
        chk("peak_count_hold", peak_count, pc);
    endtask

    initial begin
        vecs[0] = '{'{21'd5, 21'd9, 21'd3, 21'd9}, -1, 0, 1'b0, 10'd1, 21'd9, 12};
        vecs[1] = '{'{21'd5, 21'd9, 21'd3, 21'd9},  2, 4, 1'b0, 10'd1, 21'd9, 16};
        vecs[2] = '{'{21'd0, 21'd0, 21'd0, 21'd0}, -1, 0, 1'b1, 10'd0, 21'd0, 12};
        vecs[3] = '{'{21'd0, 21'd0, 21'd0, 21'd2097151}, -1, 0, 1'b0, 10'd3, 21'd2097151, 12};
        vecs[4] = '{'{21'd7, 21'd2, 21'd7, 21'd1},  0, 2, 1'b0, 10'd0, 21'd7, 14};
        vecs[5] = '{'{21'd1, 21'd2, 21'd3, 21'd4}, -1, 0, 1'b1, 10'd3, 21'd4, 12};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        res = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            mem = vecs[i].m;
            run_frame(vecs[i].m, vecs[i].sb, vecs[i].sl, vecs[i].sad, vecs[i].pa, vecs[i].pc, vecs[i].dn);
        end

        mem = vecs[0].m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_bin1", {bin_valid, bin_addr}, {1'b1, 10'd1});
        res = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(negedge clk);
        chk_zero("reset_held");
        res = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("after_reset");
        mem = vecs[0].m;
        run_frame(vecs[0].m, -1, 0, 1'b0, 10'd1, 21'd9, 12);

`ifdef READ_CLEAR_EN
        mem = vecs[0].m;
        run_frame(vecs[0].m, -1, 0, 1'b0, 10'd1, 21'd9, 12);
        run_frame(vecs[2].m, -1, 0, 1'b0, 10'd0, 21'd0, 12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
